axi4_lite_gpu_rect_sequencer: RTL
=================================

// Module: axi4_lite_gpu_rect_sequencer
// PURPOSE
// Queues rectangle-fill commands from the AXI4-Lite register front end and sequences the
// rectangle execute unit one command at a time: range-check, load corners+colour, start, await done/err.
// Sits between the register slave (cmd_* handshake) and the executor (exe_* ports); reports status/counters.
// PARAMETERS
// FRAME_WIDTH_SCALED   640  valid x range 0..FRAME_WIDTH_SCALED-1
// FRAME_HEIGHT_SCALED  480  valid y range 0..FRAME_HEIGHT_SCALED-1
// COLOR_WIDTH          8    colour field width
// FIFO_DEPTH           4    command FIFO entries, power of two, >=2
// CNT_WIDTH            16   done/err counter width
// PORTS
// clk            in   1      clock
// rst_n          in   1      synchronous active-low reset
// cmd_valid      in   1      command offered
// cmd_ready      out  1      FIFO can accept (= !full, registered state)
// cmd_x0/y0      in   12     corner A
// cmd_x1/y1      in   12     corner B
// cmd_color      in   CW     fill colour
// enable         in   1      1 = dispatch queued commands
// flush          in   1      empty FIFO (honoured in IDLE only)
// cnt_clr        in   1      zero done_cnt/err_cnt
// exe_left_valid/exe_right_valid/exe_color_valid out 1  load strobes to executor
// exe_left_x/y, exe_right_x/y out 12; exe_color out CW  load data (0 when strobes low)
// exe_start      out  1      start strobe
// exe_busy/exe_done/exe_err in 1  executor status (done/err are 1-cycle)
// busy           out  1      state != IDLE
// fifo_level     out  $clog2(FIFO_DEPTH)+1  entries incl. in-flight head
// done_cnt, err_cnt out CNT_WIDTH  completed / failed commands, wrap on overflow
// done_pulse, err_pulse out 1  1-cycle completion/failure strobes
// BEHAVIOUR
// Reset: FIFO empty, state IDLE, all outputs 0 except cmd_ready=1. Reset mid-command abandons it, no count.
// Push: cmd_valid&&cmd_ready writes tail. Head popped only on completion/reject (head held during execution).
//   Push+pop same cycle: level unchanged. Full: cmd_ready=0 even if a pop occurs that cycle.
// FSM IDLE/LOAD/START/WAIT:
//  IDLE: flush -> empty FIFO, stay IDLE. Else if enable && level>0 && !exe_busy && !exe_done && !exe_err -> LOAD.
//  LOAD (1 cyc): head in range (x<FRAME_WIDTH_SCALED, y<FRAME_HEIGHT_SCALED, both corners) -> assert all
//    three exe_*_valid with head data, -> START. Out of range -> no strobes, pop, err_cnt++, err_pulse, -> IDLE.
//  START (1 cyc): exe_start=1, -> WAIT.
//  WAIT: exe_done -> pop, done_cnt++, done_pulse, -> IDLE. exe_err -> pop, err_cnt++, err_pulse, -> IDLE.
//    Both same cycle: treat as err. No timeout.
// Min issue-to-issue: LOAD,START,WAIT(executor BUSY cycles+1 DONE),IDLE; 1x1 rect = 5 cycles.
// enable low mid-command: current command completes; no new LOAD. flush outside IDLE ignored.
// cnt_clr with simultaneous increment: clear wins (counter=0). Pulses registered, coincide with IDLE entry.
// Corners passed unordered; executor normalises min/max.
// TESTING
// Push (10,20,12,21,c=0x5A), enable=1 -> strobes 1 cyc, start next, done_cnt=1, executor writes 6 pixels.
// Push (640,0,0,0) -> no exe strobes/start, err_cnt=1, err_pulse, FIFO empty in 2 cycles.
// enable=0, push FIFO_DEPTH cmds -> cmd_ready=0, level=4; 5th push dropped; enable=1 -> 4 dones in order.
// Force exe_err in WAIT -> err_cnt+1, head popped, next command dispatched.
// rst_n low during WAIT -> next cycle all outputs 0, level=0, cmd_ready=1, counters 0.
// Queue 3, enable=0, flush=1 -> level=0, no strobes; cnt_clr with done_pulse -> done_cnt=0.

Source files
------------

// File: rtl/axi4_lite_gpu_rect_sequencer.sv
// axi4_lite_gpu_rect_sequencer
// Queues rectangle-fill commands from the register front end and hands them,
// one at a time, to the rectangle execute unit. Each command is range-checked,
// then loaded, then started, and the sequencer waits for the executor to
// finish or fail. Completion and failure are counted.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake (ready = FIFO not full)
//   cmd_x0/y0/x1/y1_i          rectangle corners (unordered)
//   cmd_color_i                fill colour
//   enable_i                   allow dispatch of queued commands
//   flush_i                    drop all queued commands (IDLE only)
//   cnt_clr_i                  zero done/err counters (wins over increment)
//   exe_*_valid_o, exe_*_o     one-cycle load strobes and data (0 when idle)
//   exe_start_o                one-cycle start strobe
//   exe_busy/done/err_i        executor status
//   busy_o                     sequencer not IDLE
//   fifo_level_o               queued entries, including the in-flight head
//   done_cnt_o, err_cnt_o      wrapping completion / failure counters
//   done_pulse_o, err_pulse_o  one-cycle strobes, coincide with IDLE entry
module axi4_lite_gpu_rect_sequencer #(
  parameter int FRAME_WIDTH_SCALED  = 640,
  parameter int FRAME_HEIGHT_SCALED = 480,
  parameter int COLOR_WIDTH         = 8,
  parameter int FIFO_DEPTH          = 4,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [11:0]                  cmd_x0_i,
  input  logic [11:0]                  cmd_y0_i,
  input  logic [11:0]                  cmd_x1_i,
  input  logic [11:0]                  cmd_y1_i,
  input  logic [COLOR_WIDTH-1:0]       cmd_color_i,
  input  logic                         enable_i,
  input  logic                         flush_i,
  input  logic                         cnt_clr_i,
  output logic                         exe_left_valid_o,
  output logic                         exe_right_valid_o,
  output logic                         exe_color_valid_o,
  output logic [11:0]                  exe_left_x_o,
  output logic [11:0]                  exe_left_y_o,
  output logic [11:0]                  exe_right_x_o,
  output logic [11:0]                  exe_right_y_o,
  output logic [COLOR_WIDTH-1:0]       exe_color_o,
  output logic                         exe_start_o,
  input  logic                         exe_busy_i,
  input  logic                         exe_done_i,
  input  logic                         exe_err_i,
  output logic                         busy_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
  output logic [CNT_WIDTH-1:0]         done_cnt_o,
  output logic [CNT_WIDTH-1:0]         err_cnt_o,
  output logic                         done_pulse_o,
  output logic                         err_pulse_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [11:0]    X_LIM = 12'(FRAME_WIDTH_SCALED);
  localparam logic [11:0]    Y_LIM = 12'(FRAME_HEIGHT_SCALED);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, START = 2'd2, WAIT = 2'd3} state_e;

  typedef struct packed {
    logic [11:0]            x0;
    logic [11:0]            y0;
    logic [11:0]            x1;
    logic [11:0]            y1;
    logic [COLOR_WIDTH-1:0] color;
  } cmd_t;

  state_e                 state_q, state_d;
  cmd_t                   mem_q [FIFO_DEPTH];
  cmd_t                   head_s, cmd_s;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   ready_q, ready_d;
  logic                   push_s, pop_s, flush_s, in_range_s;
  logic                   done_inc_s, err_inc_s;
  // The load strobe register doubles as the "head passed range check" flag in LOAD.
  logic                   load_q, load_d;
  logic [11:0]            lx_q, lx_d, ly_q, ly_d, rx_q, rx_d, ry_q, ry_d;
  logic [COLOR_WIDTH-1:0] col_q, col_d;
  logic                   start_q, start_d, busy_q, busy_d;
  logic [CNT_WIDTH-1:0]   done_cnt_q, done_cnt_d, err_cnt_q, err_cnt_d;
  logic                   done_pulse_q, done_pulse_d, err_pulse_q, err_pulse_d;

  assign cmd_s      = '{x0: cmd_x0_i, y0: cmd_y0_i, x1: cmd_x1_i, y1: cmd_y1_i, color: cmd_color_i};
  assign head_s     = mem_q[rd_ptr_q];
  assign in_range_s = (head_s.x0 < X_LIM) && (head_s.x1 < X_LIM) &&
                      (head_s.y0 < Y_LIM) && (head_s.y1 < Y_LIM);

  // Next-state, FIFO pointer and output computation.
  always_comb begin
    state_d    = state_q;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    flush_s    = 1'b0;
    done_inc_s = 1'b0;
    err_inc_s  = 1'b0;
    load_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          flush_s = 1'b1;
        end else if (enable_i && (level_q != '0) && !exe_busy_i && !exe_done_i && !exe_err_i) begin
          state_d = LOAD;
          load_d  = in_range_s;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (load_q) begin
          state_d = START;
        end else begin
          pop_s     = 1'b1;
          err_inc_s = 1'b1;
          state_d   = IDLE;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // Simultaneous done and err is treated as a failure.
        if (exe_err_i) begin
          pop_s     = 1'b1;
          err_inc_s = 1'b1;
          state_d   = IDLE;
        end else if (exe_done_i) begin
          pop_s      = 1'b1;
          done_inc_s = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase

    // A push coinciding with a flush is discarded along with the queue.
    push_s = cmd_valid_i && ready_q && !flush_s;

    if (load_d) begin
      lx_d  = head_s.x0;
      ly_d  = head_s.y0;
      rx_d  = head_s.x1;
      ry_d  = head_s.y1;
      col_d = head_s.color;
    end else begin
      lx_d  = 12'd0;
      ly_d  = 12'd0;
      rx_d  = 12'd0;
      ry_d  = 12'd0;
      col_d = '0;
    end

    if (flush_s) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d  = level_q + LVL_W'(push_s) - LVL_W'(pop_s);
    end

    ready_d      = (level_d != LVL_FULL);
    start_d      = (state_d == START);
    busy_d       = (state_d != IDLE);
    done_pulse_d = done_inc_s;
    err_pulse_d  = err_inc_s;

    if (cnt_clr_i) begin
      done_cnt_d = '0;
      err_cnt_d  = '0;
    end else begin
      done_cnt_d = done_cnt_q + CNT_WIDTH'(done_inc_s);
      err_cnt_d  = err_cnt_q + CNT_WIDTH'(err_inc_s);
    end
  end

  // Command storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= cmd_s;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ready_q      <= 1'b1;
      load_q       <= 1'b0;
      lx_q         <= 12'd0;
      ly_q         <= 12'd0;
      rx_q         <= 12'd0;
      ry_q         <= 12'd0;
      col_q        <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_cnt_q   <= '0;
      err_cnt_q    <= '0;
      done_pulse_q <= 1'b0;
      err_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ready_q      <= ready_d;
      load_q       <= load_d;
      lx_q         <= lx_d;
      ly_q         <= ly_d;
      rx_q         <= rx_d;
      ry_q         <= ry_d;
      col_q        <= col_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      done_cnt_q   <= done_cnt_d;
      err_cnt_q    <= err_cnt_d;
      done_pulse_q <= done_pulse_d;
      err_pulse_q  <= err_pulse_d;
    end
  end

  assign cmd_ready_o       = ready_q;
  assign exe_left_valid_o  = load_q;
  assign exe_right_valid_o = load_q;
  assign exe_color_valid_o = load_q;
  assign exe_left_x_o      = lx_q;
  assign exe_left_y_o      = ly_q;
  assign exe_right_x_o     = rx_q;
  assign exe_right_y_o     = ry_q;
  assign exe_color_o       = col_q;
  assign exe_start_o       = start_q;
  assign busy_o            = busy_q;
  assign fifo_level_o      = level_q;
  assign done_cnt_o        = done_cnt_q;
  assign err_cnt_o         = err_cnt_q;
  assign done_pulse_o      = done_pulse_q;
  assign err_pulse_o       = err_pulse_q;

endmodule
